// File: rtl/sudoku_pkg.sv
// Shared types and default widths for the sudoku board RAM path.
// Used by sudoku_ram_arbiter and rd_tag_pipe.
package sudoku_pkg;

    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 20;

    // Which client owns the read data that comes back out of the RAM.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CTRL = 2'd1,
        OWN_CHK  = 2'd2
    } owner_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Owner-tag shift register. It tracks which client each in-flight RAM read belongs to.
// Clearing it on reset drops every outstanding read.
module rd_tag_pipe
    import sudoku_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  owner_t tag_in,
    output owner_t tag_out,
    output logic   any_live
);

    owner_t stage [DEPTH];

    // NOTE: this small tag array is deliberately reset. Stale tags after reset would
    // produce rvalid pulses for reads that were discarded.
    // NOTE: sequential state uses non-blocking assignments, so each stage takes its
    // neighbour's value from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

    // NOTE: always_comb outputs get a default first, so no path can infer a latch.
    always_comb begin
        any_live = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage[i] != OWN_NONE) any_live = 1'b1;
        end
    end

endmodule

// File: rtl/sudoku_ram_arbiter.sv
// Arbitrates the single sudoku RAM port between the controller (rd/wr) and the checker (rd).
// Optional checker starvation guard: define ARB_STARVE_GUARD_EN.
module sudoku_ram_arbiter
    import sudoku_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              k_req,
    input  logic [ADDR_W-1:0] k_addr,
    output logic              k_gnt,
    output logic              k_rvalid,
    output logic [DATA_W-1:0] k_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              write_kick,
    output logic              busy
);

    logic   grant_c;
    logic   grant_k;
    logic   starve_hit;
    owner_t tag_in;
    owner_t tag_out;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));

    // Count the edges the checker waits while the controller is granted. Saturate at the threshold.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            starve_cnt <= '0;
        end else if (grant_k) begin
            starve_cnt <= '0;
        end else if (k_req && !starve_hit) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign starve_hit = (STARVE_MAX < 0);
`endif

    always_comb begin
        grant_k = k_req && (!c_req || starve_hit);
        grant_c = c_req && !grant_k;
        tag_in  = OWN_NONE;
        if (grant_c && !c_we) tag_in = OWN_CTRL;
        else if (grant_k)     tag_in = OWN_CHK;
    end

    rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
        .clk      (CLK),
        .rst_n    (RST),
        .tag_in   (tag_in),
        .tag_out  (tag_out),
        .any_live (busy)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            c_gnt      <= 1'b0;
            k_gnt      <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_wren   <= 1'b0;
            write_kick <= 1'b0;
            c_rvalid   <= 1'b0;
            k_rvalid   <= 1'b0;
            c_rdata    <= '0;
            k_rdata    <= '0;
        end else begin
            c_gnt      <= grant_c;
            k_gnt      <= grant_k;
            ram_wren   <= grant_c && c_we;
            write_kick <= ram_wren;
            if (grant_c) begin
                ram_addr  <= c_addr;
                ram_wdata <= c_wdata;
            end else if (grant_k) begin
                ram_addr  <= k_addr;
            end
            // Read data leaves the RAM as its tag reaches the end of the pipe.
            c_rvalid <= (tag_out == OWN_CTRL);
            k_rvalid <= (tag_out == OWN_CHK);
            if (tag_out == OWN_CTRL) c_rdata <= ram_q;
            if (tag_out == OWN_CHK)  k_rdata <= ram_q;
        end
    end

endmodule

// File: tb/tb_sudoku_ram_arbiter.sv
// Directed, scoreboarded bench for sudoku_ram_arbiter with a write-first, 1-cycle RAM model.
// The expected starvation behaviour follows ARB_STARVE_GUARD_EN.
module tb_sudoku_ram_arbiter;

    logic        CLK;
    logic        RST;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [1:0]  c_addr;
    logic [19:0] c_wdata, c_rdata;
    logic        k_req, k_gnt, k_rvalid;
    logic [1:0]  k_addr;
    logic [19:0] k_rdata;
    logic [1:0]  ram_addr;
    logic [19:0] ram_wdata, ram_q;
    logic        ram_wren, write_kick, busy;

    typedef struct packed {
        bit          is_chk;
        logic [19:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          rv_seen = 0;
    logic [19:0] mem [4];

    sudoku_ram_arbiter dut (
        .CLK(CLK), .RST(RST),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .k_req(k_req), .k_addr(k_addr),
        .k_gnt(k_gnt), .k_rvalid(k_rvalid), .k_rdata(k_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
        .write_kick(write_kick), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Write-first synchronous RAM, one clock address-to-q.
    always @(posedge CLK) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= ram_wren ? ram_wdata : mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: each rvalid pops the oldest expected read.
    always @(negedge CLK) begin
        if (RST && (c_rvalid || k_rvalid)) begin
            exp_t e;
            rv_seen++;
            check("rv_single_owner", {31'd0, c_rvalid && k_rvalid}, 32'd0);
            if (sb.size() == 0) begin
                check("rv_expected", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("rv_owner", {31'd0, k_rvalid}, {31'd0, e.is_chk});
                check("rv_data", {12'd0, k_rvalid ? k_rdata : c_rdata}, {12'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rv_before;
        RST = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        k_req = 1'b1; k_addr = '0;

        // Reset held with both requests asserted.
        tick(); tick();
        check("rst_gnt", {30'd0, c_gnt, k_gnt}, 32'd0);
        check("rst_rvalid", {30'd0, c_rvalid, k_rvalid}, 32'd0);
        check("rst_rdata", {c_rdata[15:0], k_rdata[15:0]}, 32'd0);
        check("rst_ram", {9'd0, ram_addr, ram_wdata, ram_wren}, 32'd0);
        check("rst_kick_busy", {30'd0, write_kick, busy}, 32'd0);
        c_req = 1'b0; k_req = 1'b0;
        #2 RST = 1'b1;
        tick(); tick();
        check("idle_wren_busy", {30'd0, ram_wren, busy}, 32'd0);

        // Controller write of row 2.
        c_req = 1'b1; c_we = 1'b1; c_addr = 2'd2; c_wdata = 20'h12345;
        tick();
        check("wr_gnt", {31'd0, c_gnt}, 32'd1);
        check("wr_ram", {9'd0, ram_addr, ram_wdata, ram_wren}, {9'd0, 2'd2, 20'h12345, 1'b1});
        c_req = 1'b0;
        tick();
        check("wr_kick", {30'd0, write_kick, c_gnt}, 32'd2);
        tick();
        check("wr_kick_once", {31'd0, write_kick}, 32'd0);

        // Controller read of row 2.
        c_req = 1'b1; c_we = 1'b0; c_addr = 2'd2;
        sb.push_back('{is_chk: 1'b0, data: 20'h12345});
        tick();
        check("rd_gnt", {30'd0, c_gnt, ram_wren}, 32'd2);
        c_req = 1'b0;
        tick();
        check("rd_busy", {30'd0, busy, c_rvalid}, 32'd2);
        tick();
        check("rd_rvalid", {11'd0, c_rvalid, c_rdata}, {11'd0, 1'b1, 20'h12345});
        tick();
        check("rd_hold", {11'd0, c_rvalid, c_rdata}, {11'd0, 1'b0, 20'h12345});
        check("rd_idle_busy", {31'd0, busy}, 32'd0);

        // Simultaneous controller write and checker read of row 1.
        c_req = 1'b1; c_we = 1'b1; c_addr = 2'd1; c_wdata = 20'h0ABCD;
        k_req = 1'b1; k_addr = 2'd1;
        sb.push_back('{is_chk: 1'b1, data: 20'h0ABCD});
        tick();
        check("sim_e0_gnt", {30'd0, c_gnt, k_gnt}, 32'd2);
        c_req = 1'b0;
        tick();
        check("sim_e1", {29'd0, write_kick, k_gnt, c_gnt}, 32'd6);
        check("sim_e1_addr", {30'd0, ram_addr}, 32'd1);
        k_req = 1'b0;
        tick();
        check("sim_e2_rvalid", {31'd0, k_rvalid}, 32'd0);
        tick();
        check("sim_e3_rdata", {11'd0, k_rvalid, k_rdata}, {11'd0, 1'b1, 20'h0ABCD});

        // Back-to-back writes: rows 0..3 get 1..4.
        for (int i = 0; i < 4; i++) begin
            c_req = 1'b1; c_we = 1'b1; c_addr = 2'(i); c_wdata = 20'(i + 1);
            tick();
            check("b2b_wr_gnt", {30'd0, c_gnt, ram_addr}, {29'd0, 1'b1, 2'(i)});
        end
        c_req = 1'b0;

        // Alternating controller/checker reads, one per cycle.
        for (int i = 0; i < 4; i++) begin
            c_we = 1'b0;
            c_req = (i % 2 == 0);
            k_req = (i % 2 == 1);
            c_addr = 2'(i); k_addr = 2'(i);
            sb.push_back('{is_chk: (i % 2 == 1), data: 20'(i + 1)});
            tick();
            check("ilv_gnt", {30'd0, c_gnt, k_gnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
        end
        c_req = 1'b0; k_req = 1'b0;
        for (int n = 0; n < 10 && sb.size() != 0; n++) tick();
        check("ilv_drained", 32'(sb.size()), 32'd0);

        // Starvation: controller writes row 0 (same value), checker reads row 3, both held.
        c_req = 1'b1; c_we = 1'b1; c_addr = 2'd0; c_wdata = 20'h1;
        k_req = 1'b1; k_addr = 2'd3;
        sb.push_back('{is_chk: 1'b1, data: 20'h4});
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stv_ctrl_wins", {30'd0, c_gnt, k_gnt}, 32'd2);
        end
`ifdef ARB_STARVE_GUARD_EN
        tick();
        check("stv_guard_k", {30'd0, c_gnt, k_gnt}, 32'd1);
        k_req = 1'b0;
        tick();
        check("stv_ctrl_resume", {30'd0, c_gnt, k_gnt}, 32'd2);
        c_req = 1'b0;
`else
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stv_strict", {30'd0, c_gnt, k_gnt}, 32'd2);
        end
        c_req = 1'b0;
        tick();
        check("stv_k_after_c", {30'd0, c_gnt, k_gnt}, 32'd1);
        k_req = 1'b0;
`endif
        for (int n = 0; n < 10 && sb.size() != 0; n++) tick();
        check("stv_drained", 32'(sb.size()), 32'd0);
        tick();

        // Reset in the middle of a controller read.
        rv_before = rv_seen;
        c_req = 1'b1; c_we = 1'b0; c_addr = 2'd2;
        tick();
        check("mid_gnt", {31'd0, c_gnt}, 32'd1);
        c_req = 1'b0;
        tick();
        #1 RST = 1'b0;
        #2 RST = 1'b1;
        check("mid_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("mid_no_rvalid", 32'(rv_seen - rv_before), 32'd0);
        check("final_queue", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
